window_gen_kxk: RTL
===================

# window_gen_kxk

Parametrised KxK sliding-window generator for the image pipeline. It accepts a raster-order pixel stream and keeps K-1 line buffers internally, so no external row FIFOs are needed. Each accepted pixel updates a KxK window, and a `window_valid` strobe marks when a full neighbourhood is present. It sits between the pixel source and the averaging, edge-detection and other KxK kernel stages, and replaces the fixed 3x3 window register.

## Interface
- `PIXEL_SIZE`, 8, bit-width of one pixel
- `IMG_WIDTH`, 640, pixels per row; must be ≥ K
- `IMG_HEIGHT`, 480, rows per frame; must be ≥ K
- `K`, 3, window size; odd, legal range 3..7
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `frame_start`  in  1  synchronous restart of the position counters
- `pixel_valid`  in  1  `pixel_in` is accepted this cycle
- `pixel_in`  in  PIXEL_SIZE  raster-order pixel
- `window`  out  PIXEL_SIZE × [0:K-1][0:K-1]
  - Row 0 is the oldest row; row K-1 is the current row.
  - Column K-1 is the newest pixel.
- `window_valid`  out  1  one-cycle strobe: `window` holds a complete neighbourhood
- `frame_done`  out  1  one-cycle strobe: the last pixel of the frame was accepted

## Operation
- Position counters:
  - `in_col` runs 0..IMG_WIDTH-1; `in_row` runs 0..IMG_HEIGHT-1.
  - Both advance only on an accepted pixel.
  - `in_col` wraps to 0 and increments `in_row`.
  - At (W-1, H-1) both wrap to 0 and `frame_done` pulses.
- Line buffers: K-1 buffers, each IMG_WIDTH deep.
  - Each accepted pixel reads every buffer at address `in_col`.
  - Buffer 0 writes `pixel_in`; buffer i writes the value read from buffer i-1.
  - Read-during-write returns the old data.
- Window update on each accepted pixel:
  - Every row shifts left by one column.
  - `window[K-1][K-1]` ← `pixel_in`.
  - `window[K-1-j][K-1]` ← buffer j-1 read data, for j = 1..K-1.
- `window_valid` is set for the accepted pixel when `in_row ≥ K-1` and `in_col ≥ K-1` (macro off).
- `frame_start`:
  - Counters clear to 0. Line buffers and the window are not cleared; stale data is never flagged valid.
  - If `frame_start` and `pixel_valid` are high in the same cycle, the pixel is (0,0).
  - `frame_start` mid-frame aborts the frame, and no `frame_done` pulse is issued.
- `pixel_valid` low: window, counters and buffers hold; `window_valid` and `frame_done` are 0.

## Timing
- Reset values: `window` all 0, `window_valid` 0, `frame_done` 0, counters 0. Buffer RAM is not reset.
- Latency: one cycle. A pixel accepted at edge n produces `window`, `window_valid` and `frame_done` after edge n+1.
- Throughput: one pixel per cycle, with no backpressure. Bubbles are allowed anywhere.
- Counter width is $clog2 of IMG_WIDTH / IMG_HEIGHT; comparisons are unsigned.
- Reset mid-frame: outputs clear immediately (asynchronous). The next pixel after release is (0,0).

## Configuration
- `WINDOW_ZERO_BORDER_EN`
- Defined:
  - `window_valid` is set for every accepted pixel with `in_row ≥ K-1`. Left-edge outputs are produced.
  - Window column c is forced to 0 when `in_col - (K-1) + c < 0`, in all rows, on the output only. The shift registers still hold the real data.
  - Valid outputs per frame: W·(H-K+1).
- Undefined:
  - Interior only. Valid outputs per frame: (W-K+1)·(H-K+1).
  - No masking logic is present.

## Structure
- `window_pkg`: default PIXEL_SIZE / IMG_WIDTH / IMG_HEIGHT / K constants, `pixel_t` typedef for the default width, and the K range constants used by elaboration-time checks.
- Sub-module `line_buffer`: single-port-style array with read-old-on-write, parametrised by depth and width. K-1 instances are created in a generate loop.
- Elaboration check: an even K, or K outside 3..7, is an error.

## Test plan
All scenarios use K=3, W=8, H=6 and a ramp input where pixel = row·16 + col.
- Full frame, no bubbles (macro off):
  - First `window_valid` follows pixel (2,2), i.e. the 19th pixel.
  - Window = {00,01,02; 10,11,12; 20,21,22}.
  - 24 valid strobes in total; `frame_done` after pixel 0x57.
- Random `pixel_valid` bubbles (about 50%): the window sequence is identical to the no-bubble run, and the window holds its value during gaps.
- Macro on:
  - Pixel (2,0) gives window {0,0,00; 0,0,10; 0,0,20} with valid.
  - 32 valid strobes per frame.
- `frame_start` pulsed at pixel (3,4), then a full frame is sent:
  - No valid strobe occurs before the new frame's (2,2).
  - No `frame_done` is issued for the aborted frame.
  - The second frame's output matches the first scenario.
- `rst_n` asserted mid-frame:
  - All outputs are 0 in the same cycle.
  - The restarted frame reproduces the first scenario exactly.
- K=5, W=8, H=6 (macro off): the first valid follows pixel (4,4), and the frame has 8 strobes.

Source files
------------

// File: rtl/window_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : window_pkg
//  Description : Default geometry constants, default pixel type and the legal
//                window-size range for the KxK window generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package window_pkg;

    localparam int PIXEL_SIZE_DEF = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int K_DEF          = 3;

    // Legal window sizes; K must also be odd
    localparam int K_MIN = 3;
    localparam int K_MAX = 7;

    typedef logic [PIXEL_SIZE_DEF-1:0] pixel_t;

endpackage
`default_nettype wire

// File: rtl/window_gen_kxk_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : One image row of storage. Asynchronous read at addr, write
//                on the clock edge; a read in the write cycle sees old data.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
    import window_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEF,
    parameter int WIDTH = PIXEL_SIZE_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    assign rd_data = mem[addr];

    // Storage is deliberately not reset; stale contents are never flagged valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_gen_kxk.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen_kxk
//  Description : KxK sliding-window generator for a raster pixel stream with
//                K-1 internal line buffers and a one-cycle output latency.
//                Optional macro WINDOW_ZERO_BORDER_EN: also emit left-edge
//                windows, with out-of-image columns forced to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module window_gen_kxk
    import window_pkg::*;
#(
    parameter int PIXEL_SIZE = PIXEL_SIZE_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int K          = K_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  pixel_valid,
    input  logic [PIXEL_SIZE-1:0] pixel_in,
    output logic [PIXEL_SIZE-1:0] window [0:K-1][0:K-1],
    output logic                  window_valid,
    output logic                  frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

    generate
        if ((K % 2) == 0 || K < K_MIN || K > K_MAX) begin : g_bad_k
            $error("window_gen_kxk: K must be odd and within 3..7");
        end
        if (IMG_WIDTH < K || IMG_HEIGHT < K) begin : g_bad_geometry
            $error("window_gen_kxk: image must be at least KxK");
        end
    endgenerate

    logic [COL_W-1:0]      in_col;
    logic [ROW_W-1:0]      in_row;
    logic [COL_W-1:0]      cur_col;
    logic [ROW_W-1:0]      cur_row;
    logic [PIXEL_SIZE-1:0] line_rd   [0:K-2];
    logic [PIXEL_SIZE-1:0] shift_win [0:K-1][0:K-1];
    logic                  pos_valid;

    // A frame_start arriving with a pixel makes that pixel (0,0)
    assign cur_col = frame_start ? '0 : in_col;
    assign cur_row = frame_start ? '0 : in_row;

`ifdef WINDOW_ZERO_BORDER_EN
    assign pos_valid = (cur_row >= ROW_FIRST);
`else
    assign pos_valid = (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
`endif

    // Line buffers chained so buffer i holds the row i+1 above the current one
    generate
        for (genvar i = 0; i < K - 1; i++) begin : g_line_buf
            logic [PIXEL_SIZE-1:0] wr_data;
            if (i == 0) begin : g_first
                assign wr_data = pixel_in;
            end else begin : g_chain
                assign wr_data = line_rd[i-1];
            end
            line_buffer #(
                .DEPTH (IMG_WIDTH),
                .WIDTH (PIXEL_SIZE)
            ) u_line_buffer (
                .clk     (clk),
                .wr_en   (pixel_valid),
                .addr    (cur_col),
                .wr_data (wr_data),
                .rd_data (line_rd[i])
            );
        end
    endgenerate

    // Raster position counters, advanced per accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col <= '0;
            in_row <= '0;
        end else if (pixel_valid) begin
            if (cur_col == COL_LAST) begin
                in_col <= '0;
                in_row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_ONE;
            end else begin
                in_col <= cur_col + COL_ONE;
                in_row <= cur_row;
            end
        end else if (frame_start) begin
            in_col <= '0;
            in_row <= '0;
        end
    end

    // Output strobes for the pixel accepted this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= pixel_valid && pos_valid;
            frame_done   <= pixel_valid && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        end
    end

    // Window shift: rows move left, new column enters from the line buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    shift_win[r][c] <= '0;
                end
            end
        end else if (pixel_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    shift_win[r][c] <= shift_win[r][c+1];
                end
            end
            shift_win[K-1][K-1] <= pixel_in;
            for (int j = 1; j < K; j++) begin
                shift_win[K-1-j][K-1] <= line_rd[j-1];
            end
        end
    end

`ifdef WINDOW_ZERO_BORDER_EN
    logic [COL_W-1:0] out_col;

    // Column of the pixel that produced the current window, for edge masking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_col <= '0;
        end else if (pixel_valid) begin
            out_col <= cur_col;
        end
    end

    // Columns left of the image edge are zeroed on the output only
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (int'(out_col) + c < K - 1) begin
                    window[r][c] = '0;
                end else begin
                    window[r][c] = shift_win[r][c];
                end
            end
        end
    end
`else
    // Interior-only build: the shift register is the output
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                window[r][c] = shift_win[r][c];
            end
        end
    end
`endif

endmodule
`default_nettype wire
